// File: rtl/tube_pkg.sv
// tube_pkg: shared depths and byte type for the Tube FIFOs.
package tube_pkg;
   localparam int TUBE_R1_PH_DEPTH = 24;
   localparam int TUBE_R3_DEPTH = 2;
   typedef logic [7:0] byte_t;
endpackage

// File: rtl/ph_fifo_if.sv
// ph_fifo_if: parasite write strobes and host read/status signals of one FIFO.
interface ph_fifo_if;
   import tube_pkg::*;
   logic  p_selectData;
   logic  p_we;
   byte_t p_data;
   logic  h_selectData;
   logic  h_rd;
   byte_t h_data;
   logic  h_data_available;
   logic  p_full;
   modport master (
      output p_selectData, p_we, p_data, h_selectData, h_rd,
      input  h_data, h_data_available, p_full
   );
   modport slave (
      input  p_selectData, p_we, p_data, h_selectData, h_rd,
      output h_data, h_data_available, p_full
   );
endinterface

// File: rtl/ph_fifo_ram.sv
// ph_fifo_ram: DEPTH x 8 storage, synchronous write, asynchronous read.
module ph_fifo_ram
   import tube_pkg::*;
#(
   parameter int DEPTH = TUBE_R1_PH_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  byte_t         wr_data,
   input  logic [AW-1:0] rd_addr,
   output byte_t         rd_data
);
   byte_t mem [DEPTH];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/ph_fifo.sv
// ph_fifo: parasite-to-host byte FIFO with occupancy flags and sticky error bits.
module ph_fifo
   import tube_pkg::*;
#(
   parameter int DEPTH = TUBE_R1_PH_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          two_byte,
   ph_fifo_if.slave      bus,
   output logic [CW-1:0] count,
   output logic          p_overrun,
   output logic          h_underrun
);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          p_overrun_q, p_overrun_d, h_underrun_q, h_underrun_d;
   logic          push, pop, push_ok, pop_ok;
   byte_t         rd_data;
   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      push         = bus.p_selectData & bus.p_we;
      pop          = bus.h_selectData & bus.h_rd;
      pop_ok       = pop & (count_q != '0);
      push_ok      = push & ((count_q != CW'(DEPTH)) | pop_ok);
      count_d      = count_q + CW'(push_ok) - CW'(pop_ok);
      wr_ptr_d     = push_ok ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = pop_ok ? inc(rd_ptr_q) : rd_ptr_q;
      p_overrun_d  = p_overrun_q | (push & ~push_ok);
      h_underrun_d = h_underrun_q | (pop & ~pop_ok);
   end
   always_ff @(posedge clk) begin
      if (rst | flush) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         p_overrun_q  <= 1'b0;
         h_underrun_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         p_overrun_q  <= p_overrun_d;
         h_underrun_q <= h_underrun_d;
      end
   end
   ph_fifo_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
      .clk     (clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.p_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );
   // Two-byte mode only reshapes the status flags; acceptance uses the true count.
   assign bus.h_data           = (count_q != '0) ? rd_data : '0;
   assign bus.h_data_available = two_byte ? (count_q >= CW'(2)) : (count_q != '0);
   assign bus.p_full           = two_byte ? (count_q >= CW'(2)) : (count_q == CW'(DEPTH));
   assign count                = count_q;
   assign p_overrun            = p_overrun_q;
   assign h_underrun           = h_underrun_q;
endmodule

// File: tb/tb_ph_fifo.sv
// tb_ph_fifo: queue scoreboard on a DEPTH=24 instance, vector table on a DEPTH=2 instance.
module tb_ph_fifo;
   import tube_pkg::*;
   logic       clk = 1'b0;
   logic       rst, flush_a, flush_b, tb_a, tb_b;
   logic [4:0] count_a;
   logic [1:0] count_b;
   logic       ovr_a, und_a, ovr_b, und_b;
   int         checks = 0;
   int         errors = 0;
   byte_t      q[$];
   bit         exp_ovr = 0;
   bit         exp_und = 0;
   typedef struct {
      bit    tb;
      bit    push;
      bit    pop;
      byte_t d;
      int    cnt;
      bit    avail;
      bit    full;
      byte_t hd;
   } vec_t;
   vec_t vecs[10];
   ph_fifo_if a();
   ph_fifo_if b();
   ph_fifo #(.DEPTH(TUBE_R1_PH_DEPTH)) u_a (
      .clk(clk), .rst(rst), .flush(flush_a), .two_byte(tb_a), .bus(a),
      .count(count_a), .p_overrun(ovr_a), .h_underrun(und_a)
   );
   ph_fifo #(.DEPTH(TUBE_R3_DEPTH)) u_b (
      .clk(clk), .rst(rst), .flush(flush_b), .two_byte(tb_b), .bus(b),
      .count(count_b), .p_overrun(ovr_b), .h_underrun(und_b)
   );
   always #5 clk = ~clk;
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic drive_a(bit push, bit pop, byte_t d);
      a.p_selectData = push; a.p_we = push; a.p_data = d;
      a.h_selectData = pop;  a.h_rd = pop;
   endtask
   task automatic drive_b(bit push, bit pop, byte_t d);
      b.p_selectData = push; b.p_we = push; b.p_data = d;
      b.h_selectData = pop;  b.h_rd = pop;
   endtask
   task automatic flags_a(string n);
      chk({n, "_count"}, count_a, q.size());
      chk({n, "_avail"}, a.h_data_available, q.size() > 0);
      chk({n, "_full"}, a.p_full, q.size() == 24);
      chk({n, "_ovr"}, ovr_a, exp_ovr);
      chk({n, "_und"}, und_a, exp_und);
      chk({n, "_data"}, a.h_data, (q.size() > 0) ? q[0] : 8'h00);
   endtask
   task automatic op_a(bit push, bit pop, byte_t d);
      bit pop_ok, push_ok;
      drive_a(push, pop, d);
      @(posedge clk); #1;
      drive_a(0, 0, 8'h00);
      pop_ok  = pop && q.size() > 0;
      push_ok = push && (q.size() < 24 || pop_ok);
      if (pop_ok) q.delete(0);
      if (push_ok) q.push_back(d);
      exp_ovr |= push && !push_ok;
      exp_und |= pop && !pop_ok;
   endtask
   initial begin
      vecs[0] = '{1, 1, 0, 8'hA1, 1, 0, 0, 8'hA1};
      vecs[1] = '{1, 1, 0, 8'hA2, 2, 1, 1, 8'hA1};
      vecs[2] = '{0, 0, 0, 8'h00, 2, 1, 1, 8'hA1};
      vecs[3] = '{0, 0, 1, 8'h00, 1, 1, 0, 8'hA2};
      vecs[4] = '{1, 0, 0, 8'h00, 1, 0, 0, 8'hA2};
      vecs[5] = '{1, 1, 1, 8'hB0, 1, 0, 0, 8'hB0};
      vecs[6] = '{0, 0, 1, 8'h00, 0, 0, 0, 8'h00};
      vecs[7] = '{1, 1, 0, 8'hC1, 1, 0, 0, 8'hC1};
      vecs[8] = '{1, 1, 0, 8'hC2, 2, 1, 1, 8'hC1};
      vecs[9] = '{1, 1, 1, 8'hC3, 2, 1, 1, 8'hC2};
      rst = 1; flush_a = 0; flush_b = 0; tb_a = 0; tb_b = 0;
      drive_a(1, 0, 8'hAA);
      drive_b(1, 0, 8'hAA);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      drive_a(0, 0, 8'h00);
      drive_b(0, 0, 8'h00);
      flags_a("reset_a");
      chk("reset_b_count", count_b, 0);
      chk("reset_b_data", b.h_data, 8'h00);
      chk("reset_b_avail", b.h_data_available, 0);
      chk("reset_b_full", b.p_full, 0);
      chk("reset_b_sticky", {ovr_b, und_b}, 0);
      for (int i = 1; i <= 24; i++) begin
         op_a(1, 0, byte_t'(i));
         flags_a("fill");
      end
      chk("fill_full", a.p_full, 1);
      chk("fill_count", count_a, 24);
      op_a(1, 0, 8'hFF);
      flags_a("drop");
      chk("drop_overrun", ovr_a, 1);
      for (int i = 1; i <= 24; i++) begin
         chk("drain_order", a.h_data, i);
         op_a(0, 1, 8'h00);
         flags_a("drain");
      end
      chk("drain_avail", a.h_data_available, 0);
      for (int i = 0; i < 20; i++) op_a(1, 0, byte_t'(8'h80 + i));
      for (int i = 0; i < 20; i++) op_a(0, 1, 8'h00);
      for (int i = 0; i < 10; i++) op_a(1, 0, byte_t'(8'h30 + i));
      flags_a("wrap_fill");
      for (int i = 0; i < 10; i++) begin
         chk("wrap_data", a.h_data, 8'h30 + i);
         op_a(0, 1, 8'h00);
         flags_a("wrap_drain");
      end
      for (int i = 0; i < 24; i++) op_a(1, 0, byte_t'(8'h60 + i));
      op_a(1, 1, 8'h55);
      flags_a("simul");
      chk("simul_count", count_a, 24);
      for (int i = 0; i < 24; i++) begin
         if (i == 23) chk("simul_last", a.h_data, 8'h55);
         op_a(0, 1, 8'h00);
         flags_a("simul_drain");
      end
      op_a(1, 1, 8'h7E);
      flags_a("empty_corner");
      chk("empty_underrun", und_a, 1);
      chk("empty_count", count_a, 1);
      chk("empty_data", a.h_data, 8'h7E);
      op_a(0, 1, 8'h00);
      for (int i = 0; i < 5; i++) op_a(1, 0, byte_t'(8'h40 + i));
      chk("pre_flush_count", count_a, 5);
      flush_a = 1;
      drive_a(1, 0, 8'h99);
      @(posedge clk); #1;
      flush_a = 0;
      drive_a(0, 0, 8'h00);
      q.delete();
      exp_ovr = 0;
      exp_und = 0;
      flags_a("flush");
      for (int i = 0; i < 10; i++) begin
         tb_b = vecs[i].tb;
         drive_b(vecs[i].push, vecs[i].pop, vecs[i].d);
         @(posedge clk); #1;
         drive_b(0, 0, 8'h00);
         chk($sformatf("vec%0d_count", i), count_b, vecs[i].cnt);
         chk($sformatf("vec%0d_avail", i), b.h_data_available, vecs[i].avail);
         chk($sformatf("vec%0d_full", i), b.p_full, vecs[i].full);
         chk($sformatf("vec%0d_data", i), b.h_data, vecs[i].hd);
      end
      chk("b_no_overrun", ovr_b, 0);
      tb_b = 0;
      drive_b(1, 0, 8'hD0);
      @(posedge clk); #1;
      drive_b(0, 0, 8'h00);
      chk("b_overrun", ovr_b, 1);
      chk("b_full_count", count_b, 2);
      chk("b_full_flag", b.p_full, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ph_fifo.md
Name: ph_fifo

Overview:
- Parasite-to-host byte FIFO; the return direction of the host-to-parasite data path.
- Parasite side writes bytes; host side reads them. Occupancy-based flags drive the parasite "not full" and host "data available" status bits.
- Instanced with DEPTH=24 for register 1 (P->H). Instanced with DEPTH=2 and two-byte mode for register 3.
- Single clock domain. Both buses are already synchronised to clk and present one-cycle strobes.

Parameters:
- DEPTH, 24, number of byte entries (2..64).
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents and error flags (Tube control T bit); same effect as rst.
- two_byte  input  1  register-3 M flag; selects two-byte threshold mode.
- p_selectData  input  1  parasite access targets this FIFO's data register.
- p_we  input  1  one-cycle parasite write strobe.
- p_data  input  8  parasite write data.
- h_selectData  input  1  host access targets this FIFO's data register.
- h_rd  input  1  one-cycle host read strobe; pops the head on this edge.
- h_data  output  8  head byte (show-ahead); 8'h00 when empty.
- h_data_available  output  1  host status bit.
- p_full  output  1  parasite status bit (1 = no room).
- count  output  CW  current occupancy, 0..DEPTH.
- p_overrun  output  1  sticky: a write was dropped.
- h_underrun  output  1  sticky: a read hit an empty FIFO.

Behaviour:
- Reset/flush: count=0, rd_ptr=wr_ptr=0, p_overrun=h_underrun=0, h_data=8'h00, h_data_available=0, p_full=0. Array contents need not be cleared. Flush overrides any write or read in the same cycle.
- push = p_selectData & p_we. pop = h_selectData & h_rd.
- Push accepted when count<DEPTH, or when count==DEPTH and a valid pop occurs in the same cycle (slot freed). Otherwise the byte is dropped and p_overrun is set.
- Pop valid when count>=1; it advances rd_ptr. A pop with count==0 is ignored and sets h_underrun. In that case a simultaneous push is still accepted, giving count=1.
- Simultaneous valid push and pop: count unchanged; both pointers advance.
- Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- h_data = mem[rd_ptr] when count>=1, else 8'h00. Combinational from registered state.
- Latency: a byte pushed at edge N appears on h_data and raises h_data_available after edge N (visible in cycle N+1). A pop at edge N presents the next byte in cycle N+1.
- Flags, normal mode (two_byte=0): h_data_available = (count>=1); p_full = (count==DEPTH).
- Flags, two-byte mode (two_byte=1): h_data_available = (count>=2); p_full = (count>=2). Push and pop acceptance still use the true count against DEPTH; only the flags change.
- Changing two_byte mid-operation affects flags only, in the same cycle; contents are kept.
- Sticky flags clear only on rst or flush.
- No outputs are registered beyond the state above; all flags derive from count.

Decomposition:
- Shared package tube_pkg:
  - TUBE_R1_PH_DEPTH=24
  - TUBE_R3_DEPTH=2
  - byte type (8-bit)
- Sub-module ph_fifo_ram: DEPTH x 8 storage with synchronous write port and asynchronous read port (wr_en, wr_addr, wr_data, rd_addr, rd_data).
- Pointer, count and flag logic stay in ph_fifo.

Test Plan:
- Reset: assert rst 2 cycles with p_we=1 and p_data=8'hAA pulsed -> count=0, h_data=8'h00, h_data_available=0, p_full=0, both sticky flags 0.
- Fill/drain, DEPTH=24:
  - Push 8'h01..8'h18 -> p_full=1 after the 24th edge, count=24.
  - 25th push of 8'hFF -> dropped, p_overrun=1.
  - 24 pops -> h_data reads 8'h01..8'h18 in order; h_data_available=0 after the last pop.
- Wrap-around and simultaneous access:
  - Push 20, pop 20, then push 10 -> pointers wrap; data 8'h30..8'h39 read back in order.
  - With count=24, push 8'h55 and pop in the same cycle -> count stays 24; 8'h55 is the last byte out.
- Empty corner: count=0, pop plus push of 8'h7E in the same cycle -> h_underrun=1, count=1, h_data=8'h7E next cycle.
- Two-byte mode, DEPTH=2:
  - two_byte=1, push 8'hA1 -> h_data_available=0, p_full=0.
  - Push 8'hA2 -> h_data_available=1, p_full=1.
  - Drop two_byte to 0 -> p_full stays 1 (count==DEPTH), h_data_available stays 1.
- Flush mid-operation: count=5, assert flush together with a push -> next cycle count=0, push discarded, sticky flags cleared.
